sha_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single SHA-256 core inside min_security_module between NUM_REQ requesters, e.g. the lifecycle authentication path and PUF signature hashing in mcse_control_unit. It accepts 512-bit blocks from the granted requester and issues init/next pulses to the core. It waits for digest completion and returns the digest to the owner. A requester keeps ownership across a multi-block message until its last block completes or an inter-block timeout expires.

---
 rtl/sha_arbiter.sv | 156 +++++++++++++++
 tb/tb_sha_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha_arbiter.sv
// sha_arbiter: round-robin arbiter/sequencer sharing one SHA-256 core among NUM_REQ requesters
//   req_valid/first/last/mode/block -> per-requester block offer, accepted by one-hot req_ready
//   rsp_valid/rsp_digest/rsp_abort  -> per-block digest return to the owner, or timeout revoke
//   sha_block/init/next/sel         -> core command; sha_ready/digest/digest_valid <- core status
//   busy                            -> high whenever the sequencer is not idle
module sha_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int BLOCK_W      = 512,
    parameter int DIGEST_W     = 256,
    parameter int HOLD_TIMEOUT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_first,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ-1:0]          req_mode,
    input  logic [NUM_REQ*BLOCK_W-1:0]  req_block,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DIGEST_W-1:0]         rsp_digest,
    output logic [NUM_REQ-1:0]          rsp_abort,
    output logic [BLOCK_W-1:0]          sha_block,
    output logic                        sha_init,
    output logic                        sha_next,
    output logic                        sha_sel,
    input  logic                        sha_ready,
    input  logic [DIGEST_W-1:0]         sha_digest,
    input  logic                        sha_digest_valid,
    output logic                        busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP, HOLD} state_t;
    state_t state, state_nx;
    logic [IW-1:0] owner, owner_nx, rr, rr_nx, win, sel;
    logic win_vld;
    logic [NUM_REQ-1:0] cand, own_oh;
    logic [BLOCK_W-1:0] blk_q, blk_nx, sel_blk;
    logic mode_q, mode_nx, first_q, first_nx, last_q, last_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DIGEST_W-1:0] dig_q, dig_nx;

    assign cand    = req_valid & req_first;
    assign own_oh  = NUM_REQ'(1) << owner;
    assign sel     = (state == IDLE) ? win : owner;
    assign sel_blk = req_block[int'(sel) * BLOCK_W +: BLOCK_W];

    // Scan downward so the candidate closest to the rr pointer is assigned last and wins.
    always_comb begin
        win = '0;
        win_vld = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand[(int'(rr) + k) % NUM_REQ]) begin
                win = IW'((int'(rr) + k) % NUM_REQ);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        owner_nx  = owner;
        rr_nx     = rr;
        blk_nx    = blk_q;
        mode_nx   = mode_q;
        first_nx  = first_q;
        last_nx   = last_q;
        cnt_nx    = cnt;
        dig_nx    = dig_q;
        req_ready = '0;
        rsp_abort = '0;
        case (state)
            IDLE: begin
                if (sha_ready && win_vld) begin
                    req_ready = NUM_REQ'(1) << win;
                    owner_nx  = win;
                    blk_nx    = sel_blk;
                    mode_nx   = req_mode[win];
                    first_nx  = 1'b1;
                    last_nx   = req_last[win];
                    rr_nx     = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
                    state_nx  = ISSUE;
                end
            end
            ISSUE:      state_nx = WAIT_START;
            // The core needs a cycle to drop sha_ready after a command.
            WAIT_START: state_nx = WAIT_DONE;
            WAIT_DONE: begin
                if (sha_ready && sha_digest_valid) begin
                    dig_nx   = sha_digest;
                    state_nx = RESP;
                end
            end
            RESP: begin
                cnt_nx   = '0;
                owner_nx = last_q ? '0 : owner;
                state_nx = last_q ? IDLE : HOLD;
            end
            HOLD: begin
                if (req_valid[owner]) begin
                    // A first block from the owner restarts its message with a fresh mode.
                    req_ready = own_oh;
                    blk_nx    = sel_blk;
                    first_nx  = req_first[owner];
                    last_nx   = req_last[owner];
                    mode_nx   = req_first[owner] ? req_mode[owner] : mode_q;
                    state_nx  = ISSUE;
                end else if (cnt == CW'(HOLD_TIMEOUT - 1)) begin
                    rsp_abort = own_oh;
                    owner_nx  = '0;
                    state_nx  = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            req_ready = '0;
            rsp_abort = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr      <= '0;
            blk_q   <= '0;
            mode_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            cnt     <= '0;
            dig_q   <= '0;
        end else begin
            state   <= state_nx;
            owner   <= owner_nx;
            rr      <= rr_nx;
            blk_q   <= blk_nx;
            mode_q  <= mode_nx;
            first_q <= first_nx;
            last_q  <= last_nx;
            cnt     <= cnt_nx;
            dig_q   <= dig_nx;
        end
    end

    assign rsp_valid  = (state == RESP) ? own_oh : '0;
    assign rsp_digest = dig_q;
    assign sha_block  = blk_q;
    assign sha_init   = (state == ISSUE) && first_q;
    assign sha_next   = (state == ISSUE) && !first_q;
    assign sha_sel    = (state != IDLE) && mode_q;
    assign busy       = state != IDLE;
endmodule

// File: tb/tb_sha_arbiter.sv
// tb_sha_arbiter: directed scoreboard bench for sha_arbiter with a behavioural SHA core stub
module tb_sha_arbiter;
    localparam int NR = 2, BW = 512, DW = 256, HT = 64;
    localparam logic [BW-1:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
    localparam logic [DW-1:0] ABC_DIG =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    typedef struct {
        int            idx;
        logic [DW-1:0] dig;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [NR-1:0] req_valid = '0, req_first = '0, req_last = '0, req_mode = '0;
    logic [NR*BW-1:0] req_block = '0;
    logic [NR-1:0] req_ready, rsp_valid, rsp_abort;
    logic [DW-1:0] rsp_digest, sha_digest;
    logic [BW-1:0] sha_block;
    logic sha_init, sha_next, sha_sel, sha_ready, sha_digest_valid, busy;

    logic core_idle = 1'b1, core_dv = 1'b0, ready_block = 1'b0, c_mode = 1'b0;
    logic [DW-1:0] core_dig = '0;
    logic [BW-1:0] c_blk = '0;
    int core_cnt = 0, core_lat = 5, c_lat = 0;

    int checks = 0, errors = 0, cyc = 0, n_init = 0, n_next = 0;
    int abort_cyc = -1, abort_who = -1;
    int grant_cyc[NR], rsp_cyc[NR];
    int grant_log[$];
    exp_t exp_q[$];

    sha_arbiter #(.NUM_REQ(NR), .BLOCK_W(BW), .DIGEST_W(DW), .HOLD_TIMEOUT(HT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_first(req_first), .req_last(req_last),
        .req_mode(req_mode), .req_block(req_block), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_digest(rsp_digest), .rsp_abort(rsp_abort),
        .sha_block(sha_block), .sha_init(sha_init), .sha_next(sha_next), .sha_sel(sha_sel),
        .sha_ready(sha_ready), .sha_digest(sha_digest), .sha_digest_valid(sha_digest_valid),
        .busy(busy)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [DW-1:0] xd(logic [BW-1:0] b, logic m);
        return b[DW-1:0] ^ {DW{m}};
    endfunction

    function automatic logic [BW-1:0] rnd();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Core stub: a command drops sha_ready for c_lat cycles, then presents the digest.
    assign sha_ready        = core_idle & ~ready_block;
    assign sha_digest       = core_dig;
    assign sha_digest_valid = core_dv;

    always @(posedge clk) begin
        if (sha_init | sha_next) begin
            c_blk  = sha_block;
            c_mode = sha_sel;
            c_lat  = core_lat;
            #1;
            core_idle = 1'b0;
            core_dv   = 1'b0;
            core_cnt  = c_lat;
        end else begin
            #1;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0) begin
                    core_idle = 1'b1;
                    core_dv   = 1'b1;
                    core_dig  = (c_blk == ABC_BLK) ? ABC_DIG : xd(c_blk, c_mode);
                end
            end
        end
    end

    task automatic chk(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic present(int i, logic f, logic l, logic m, logic [BW-1:0] b, logic [DW-1:0] e);
        req_valid[i] = 1'b1;
        req_first[i] = f;
        req_last[i]  = l;
        req_mode[i]  = m;
        req_block[i*BW +: BW] = b;
        exp_q.push_back('{idx: i, dig: e});
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        exp_t e;
        @(negedge clk);
        cyc++;
        acc = req_ready;
        chk("onehot", {$onehot0(req_ready), $onehot0(rsp_valid), $onehot0(rsp_abort)}, 3'b111);
        chk("ready_gate", (|req_ready) & ~sha_ready, 0);
        n_init += int'(sha_init);
        n_next += int'(sha_next);
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                grant_cyc[i] = cyc;
                grant_log.push_back(i);
            end
            if (rsp_valid[i]) rsp_cyc[i] = cyc;
            if (rsp_abort[i]) begin
                abort_cyc = cyc;
                abort_who = i;
            end
        end
        if (rsp_valid != 0) begin
            if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                e = exp_q.pop_front();
                chk("rsp_owner", rsp_valid, NR'(1) << e.idx);
                chk("rsp_digest", rsp_digest, e.dig);
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic wait_done(string tag, int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy || req_valid != 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (exp_q.size() == 0 && !busy && req_valid == 0), 1);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_ctrl"}, {busy, req_ready, rsp_valid, rsp_abort, sha_init, sha_next, sha_sel}, 0);
        chk({tag, "_block"}, sha_block, 0);
        chk({tag, "_digest"}, rsp_digest, 0);
    endtask

    initial begin
        logic [BW-1:0] b, b2;
        int bi, bn, g, t;
        repeat (3) tick();
        rst = 1'b0;
        chk_zero("reset");

        bi = n_init; bn = n_next;
        present(0, 1, 1, 1, ABC_BLK, ABC_DIG);
        wait_done("abc_done", 100);
        chk("abc_inits", n_init - bi, 1);
        chk("abc_nexts", n_next - bn, 0);

        ready_block = 1'b1;
        bi = n_init; g = grant_log.size();
        b = rnd();
        present(1, 1, 1, 0, b, xd(b, 0));
        repeat (10) tick();
        chk("rdy_low_grant", grant_log.size() - g, 0);
        chk("rdy_low_init", n_init - bi, 0);
        ready_block = 1'b0;
        wait_done("rdy_low_done", 100);
        chk("rdy_low_grant_after", grant_log.size() - g, 1);

        grant_log.delete();
        b = rnd(); b2 = rnd();
        present(0, 1, 1, 0, b, xd(b, 0));
        present(1, 1, 1, 1, b2, xd(b2, 1));
        wait_done("rr1_done", 200);
        chk("rr1_count", grant_log.size(), 2);
        chk("rr1_first", grant_log[0], 0);
        chk("rr1_second", grant_log[1], 1);
        b = rnd();
        present(0, 1, 1, 1, b, xd(b, 1));
        wait_done("rr_solo_done", 100);
        grant_log.delete();
        b = rnd(); b2 = rnd();
        present(1, 1, 1, 0, b2, xd(b2, 0));
        present(0, 1, 1, 1, b, xd(b, 1));
        wait_done("rr2_done", 200);
        chk("rr2_count", grant_log.size(), 2);
        chk("rr2_first", grant_log[0], 1);
        chk("rr2_second", grant_log[1], 0);

        bi = n_init; bn = n_next;
        b = rnd(); b2 = rnd();
        present(1, 1, 0, 1, b, xd(b, 1));
        t = 0;
        while (req_valid[1] && t < 50) begin tick(); t++; end
        present(1, 0, 1, 0, b2, xd(b2, 1));
        present(0, 1, 1, 0, b, xd(b, 0));
        wait_done("mb_done", 200);
        chk("mb_inits", n_init - bi, 2);
        chk("mb_nexts", n_next - bn, 1);
        chk("mb_order", grant_cyc[0] - rsp_cyc[1], 1);

        b = rnd();
        present(1, 1, 0, 0, b, xd(b, 0));
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin tick(); t++; end
        b2 = rnd();
        present(0, 1, 1, 1, b2, xd(b2, 1));
        abort_cyc = -1;
        t = 0;
        while (abort_cyc < 0 && t < 200) begin tick(); t++; end
        chk("to_delay", abort_cyc - rsp_cyc[1], HT);
        chk("to_who", abort_who, 1);
        wait_done("to_done", 100);
        chk("to_grant", grant_cyc[0] - abort_cyc, 1);

        core_lat = 20;
        b = rnd();
        bi = n_init;
        present(0, 1, 1, 0, b, xd(b, 0));
        t = 0;
        while (n_init == bi && t < 50) begin tick(); t++; end
        repeat (2) tick();
        core_lat = 5;
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("rst_mid");
        b2 = rnd();
        present(1, 1, 1, 1, b2, xd(b2, 1));
        wait_done("rst_recover", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
